arinc_rx_word_fifo: RTL

//  Receive-side word buffer directly downstream of the ARINC429 bit decoder.

---
 rtl/arinc_rx_word_fifo.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/arinc_rx_word_fifo.sv
// ---------------------------------------------------------------------------
// arinc_rx_word_fifo
//   Receive-side word buffer that sits behind the ARINC429 bit decoder.
//   Each word strobed by the decoder is parity checked (odd parity over all
//   32 bits). Words that pass are queued in a synchronous FIFO until the host
//   reads them. A parity error is reported as a one-cycle pulse. A word that
//   is lost because the FIFO is full sets a sticky overflow flag.
//
//   Optional feature macro: ARINC_RX_LABEL_FILTER_EN
//     Adds a 256-entry per-label enable table and its write port.
//     A word whose label entry is 0 is discarded silently.
//
// Ports
//   Clk        in   system clock, posedge
//   Rst        in   synchronous reset, active-high
//   In         in   decoded word ([7:0] label, [31] parity)
//   In_valid   in   one-cycle strobe for In
//   Rd_en      in   host read request, one word per cycle
//   Ovf_clr    in   clears Overflow (a same-cycle overflow wins)
//   Lbl_wr     in   label table write strobe     (filter builds only)
//   Lbl_addr   in   label table entry to write   (filter builds only)
//   Lbl_data   in   new enable bit for the entry (filter builds only)
//   Out        out  word read from the FIFO, held between reads
//   Out_valid  out  one-cycle pulse: Out was updated by a read
//   Empty      out  FIFO holds no words
//   Full       out  FIFO holds DEPTH words
//   Count      out  number of stored words, 0..DEPTH
//   Par_err    out  one-cycle pulse: the previous strobed word had even parity
//   Overflow   out  sticky: a word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module arinc_rx_word_fifo #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int PAR_CHK = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [31:0]       In,
    input  logic              In_valid,
    input  logic              Rd_en,
    input  logic              Ovf_clr,
`ifdef ARINC_RX_LABEL_FILTER_EN
    input  logic              Lbl_wr,
    input  logic [7:0]        Lbl_addr,
    input  logic              Lbl_data,
`endif
    output logic [31:0]       Out,
    output logic              Out_valid,
    output logic              Empty,
    output logic              Full,
    output logic [ADDR_W:0]   Count,
    output logic              Par_err,
    output logic              Overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam bit              CHK_ON   = (PAR_CHK != 0);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              par_ok;
    logic              lbl_pass;
    logic              accept;
    logic              rd_eff;
    logic              wr_eff;
    logic              drop;

`ifdef ARINC_RX_LABEL_FILTER_EN
    logic [255:0] lbl_en;

    // The table is read combinationally from its registered value, so a
    // write only affects words strobed on later cycles.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            lbl_en <= '1;
        end else if (Lbl_wr) begin
            lbl_en[Lbl_addr] <= Lbl_data;
        end
    end

    assign lbl_pass = lbl_en[In[7:0]];
`else
    assign lbl_pass = 1'b1;
`endif

    assign par_ok = ^In;
    assign accept = In_valid & lbl_pass & (par_ok | ~CHK_ON);
    assign rd_eff = Rd_en & ~Empty;
    // When full, a same-cycle read frees the slot the write lands in.
    assign wr_eff = accept & (~Full | rd_eff);
    assign drop   = accept & Full & ~rd_eff;

    always_comb begin
        count_nxt = Count;
        if (wr_eff && !rd_eff) begin
            count_nxt = Count + 1'b1;
        end else if (rd_eff && !wr_eff) begin
            count_nxt = Count - 1'b1;
        end
    end

    // Storage is not reset; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        if (!Rst && wr_eff) begin
            mem[wr_ptr] <= In;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Count     <= '0;
            Empty     <= 1'b1;
            Full      <= 1'b0;
            Out       <= '0;
            Out_valid <= 1'b0;
            Par_err   <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            if (wr_eff) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
                Out    <= mem[rd_ptr];
            end
            Out_valid <= rd_eff;
            Count     <= count_nxt;
            Empty     <= (count_nxt == '0);
            Full      <= (count_nxt == FULL_CNT);
            Par_err   <= In_valid & ~par_ok;
            if (drop) begin
                Overflow <= 1'b1;
            end else if (Ovf_clr) begin
                Overflow <= 1'b0;
            end
        end
    end

endmodule
